// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller:
// FSM state encoding, control-output bundle, statistics counter width.
package pipeline_hazard_ctrl_pkg;

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_FLUSH      = 2'd2,
    ST_MEM_WAIT   = 2'd3
  } hz_state_e;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_bubble;
    logic idex_hold;
    logic exmem_hold;
  } hz_ctrl_t;

  // Increment by one when enabled, sticking at the all-ones value.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt, input logic en);
    if (en && (cnt != CNT_MAX)) begin
      return cnt + CNT_W'(1);
    end else begin
      return cnt;
    end
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-detection inputs from the pipeline registers and the stall/flush
// controls and statistics returned by the controller.
interface pipeline_hazard_ctrl_if;

  logic        idexMemoryRead;
  logic [4:0]  idexRt;
  logic [4:0]  ifidRs;
  logic [4:0]  ifidRt;
  logic        ifidUsesRt;
  logic        branchTaken;
  logic        memoryBusy;
  logic        statClear;
  logic        pcWrite;
  logic        ifidWrite;
  logic        ifidFlush;
  logic        idexBubble;
  logic        idexHold;
  logic        exmemHold;
  logic [15:0] stallCycles;
  logic [15:0] flushCount;
  logic [1:0]  state;

  modport master (
    output idexMemoryRead, idexRt, ifidRs, ifidRt, ifidUsesRt,
           branchTaken, memoryBusy, statClear,
    input  pcWrite, ifidWrite, ifidFlush, idexBubble, idexHold, exmemHold,
           stallCycles, flushCount, state
  );

  modport slave (
    input  idexMemoryRead, idexRt, ifidRs, ifidRt, ifidUsesRt,
           branchTaken, memoryBusy, statClear,
    output pcWrite, ifidWrite, ifidFlush, idexBubble, idexHold, exmemHold,
           stallCycles, flushCount, state
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_load_use_compare.sv
// Load-use detector: the load in ID/EX writes a register the IF/ID
// instruction reads. Register 0 never creates a dependency.
module load_use_compare (
  input  logic       i_mem_read,
  input  logic [4:0] i_idex_rt,
  input  logic [4:0] i_ifid_rs,
  input  logic [4:0] i_ifid_rt,
  input  logic       i_ifid_uses_rt,
  output logic       o_hit
);

  logic w_rs_match;
  logic w_rt_match;

  assign w_rs_match = (i_idex_rt == i_ifid_rs);
  assign w_rt_match = i_ifid_uses_rt && (i_idex_rt == i_ifid_rt);
  assign o_hit      = i_mem_read && (i_idex_rt != 5'd0) && (w_rs_match || w_rt_match);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: Mealy FSM arbitrating memory wait, taken
// branch and load-use stalls, plus saturating stall/flush statistics.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
(
  input logic                 clock,
  input logic                 reset,
  pipeline_hazard_ctrl_if.slave bus
);

  hz_state_e        r_state;
  hz_state_e        w_next_state;
  hz_ctrl_t         w_ctrl;
  logic             w_hit;
  logic             w_masked;
  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_flush_count;

  load_use_compare u_load_use (
    .i_mem_read     (bus.idexMemoryRead),
    .i_idex_rt      (bus.idexRt),
    .i_ifid_rs      (bus.ifidRs),
    .i_ifid_rt      (bus.ifidRt),
    .i_ifid_uses_rt (bus.ifidUsesRt),
    .o_hit          (w_hit)
  );

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_next_state;
    end
  end

  // The cycle after a stall or flush already inserted a bubble, so the
  // same load-use pair must not stall twice.
  always_comb begin
    case (r_state)
      ST_LOAD_STALL, ST_FLUSH: w_masked = 1'b1;
      default:                 w_masked = 1'b0;
    endcase
  end

  // Next-state selection, priority memoryBusy > branchTaken > load-use.
  always_comb begin
    w_next_state = ST_RUN;
    if (bus.memoryBusy) begin
      w_next_state = ST_MEM_WAIT;
    end else if (bus.branchTaken) begin
      w_next_state = ST_FLUSH;
    end else if (w_hit && !w_masked) begin
      w_next_state = ST_LOAD_STALL;
    end else begin
      w_next_state = ST_RUN;
    end
  end

  // Control outputs; reset drives the pipeline into a safe bubbling state.
  always_comb begin
    w_ctrl = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0,
               idex_bubble: 1'b0, idex_hold: 1'b0, exmem_hold: 1'b0};
    if (reset) begin
      w_ctrl = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b1,
                 idex_bubble: 1'b1, idex_hold: 1'b0, exmem_hold: 1'b0};
    end else if (bus.memoryBusy) begin
      w_ctrl = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
                 idex_bubble: 1'b0, idex_hold: 1'b1, exmem_hold: 1'b1};
    end else if (bus.branchTaken) begin
      w_ctrl.ifid_flush  = 1'b1;
      w_ctrl.idex_bubble = 1'b1;
    end else if (w_hit && !w_masked) begin
      w_ctrl.pc_write    = 1'b0;
      w_ctrl.ifid_write  = 1'b0;
      w_ctrl.idex_bubble = 1'b1;
    end else begin
      w_ctrl.pc_write    = 1'b1;
    end
  end

  // Statistics counters; statClear wins over any increment.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else if (bus.statClear) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      r_stall_cycles <= sat_inc(r_stall_cycles, !w_ctrl.pc_write);
      r_flush_count  <= sat_inc(r_flush_count, w_ctrl.ifid_flush);
    end
  end

  assign bus.pcWrite     = w_ctrl.pc_write;
  assign bus.ifidWrite   = w_ctrl.ifid_write;
  assign bus.ifidFlush   = w_ctrl.ifid_flush;
  assign bus.idexBubble  = w_ctrl.idex_bubble;
  assign bus.idexHold    = w_ctrl.idex_hold;
  assign bus.exmemHold   = w_ctrl.exmem_hold;
  assign bus.stallCycles = r_stall_cycles;
  assign bus.flushCount  = r_flush_count;
  assign bus.state       = r_state;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench: directed scenarios plus randomized traffic compared
// against a rule-level model of the hazard controller.
module tb_pipeline_hazard_ctrl;

  logic clock;
  logic reset;
  int   n_cmp;
  int   n_err;

  // Model: control bits ordered {pc, ifw, flush, bubble, idexHold, exmemHold}
  logic [1:0]  m_state;
  logic [15:0] m_stall;
  logic [15:0] m_flush;

  pipeline_hazard_ctrl_if bus ();

  pipeline_hazard_ctrl dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [5:0] dut_ctl();
    return {bus.pcWrite, bus.ifidWrite, bus.ifidFlush,
            bus.idexBubble, bus.idexHold, bus.exmemHold};
  endfunction

  function automatic void model_eval(output logic [5:0] ctl, output logic [1:0] nxt);
    bit hit;
    bit masked;
    hit = bus.idexMemoryRead && (bus.idexRt != 5'd0) &&
          ((bus.idexRt == bus.ifidRs) || (bus.ifidUsesRt && (bus.idexRt == bus.ifidRt)));
    masked = (m_state == 2'd1) || (m_state == 2'd2);
    if (reset)                  begin ctl = 6'b001100; nxt = 2'd0; end
    else if (bus.memoryBusy)    begin ctl = 6'b000011; nxt = 2'd3; end
    else if (bus.branchTaken)   begin ctl = 6'b111100; nxt = 2'd2; end
    else if (hit && !masked)    begin ctl = 6'b000100; nxt = 2'd1; end
    else                        begin ctl = 6'b110000; nxt = 2'd0; end
  endfunction

  task automatic set_inputs(input bit mr, input int rt, input int rs, input int ifrt,
                            input bit uses, input bit br, input bit busy, input bit clr);
    bus.idexMemoryRead = mr;
    bus.idexRt         = 5'(rt);
    bus.ifidRs         = 5'(rs);
    bus.ifidRt         = 5'(ifrt);
    bus.ifidUsesRt     = uses;
    bus.branchTaken    = br;
    bus.memoryBusy     = busy;
    bus.statClear      = clr;
  endtask

  // Advance one clock, updating the model from the inputs present at the edge.
  task automatic tick();
    logic [5:0] c;
    logic [1:0] n;
    model_eval(c, n);
    @(posedge clock);
    if (reset) begin
      m_state = 2'd0; m_stall = 16'd0; m_flush = 16'd0;
    end else begin
      m_state = n;
      if (bus.statClear) begin
        m_stall = 16'd0; m_flush = 16'd0;
      end else begin
        if (!c[5] && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
        if (c[3] && m_flush != 16'hFFFF)  m_flush = m_flush + 16'd1;
      end
    end
    #1;
  endtask

  task automatic clear_stats();
    set_inputs(0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    bus.statClear = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_inputs(0, 0, 0, 0, 0, 0, 0, 0);
    m_state = 2'd0; m_stall = 16'd0; m_flush = 16'd0;
    #2;
    n_cmp++;
    if (dut_ctl() !== 6'b001100) begin
      n_err++; $display("FAIL reset_ctl: got %b expected %b", dut_ctl(), 6'b001100);
    end
    n_cmp++;
    if (bus.state !== 2'd0 || bus.stallCycles !== 16'd0 || bus.flushCount !== 16'd0) begin
      n_err++; $display("FAIL reset_state: got st=%0d stall=%0d flush=%0d expected 0/0/0",
                        bus.state, bus.stallCycles, bus.flushCount);
    end
    tick();
    tick();
    reset = 1'b0;
    #1;
    n_cmp++;
    if (dut_ctl() !== 6'b110000) begin
      n_err++; $display("FAIL reset_release_ctl: got %b expected %b", dut_ctl(), 6'b110000);
    end
  endtask

  task automatic test_load_use();
    clear_stats();
    set_inputs(1, 5, 5, 0, 0, 0, 0, 0);
    #1;
    n_cmp++;
    if (dut_ctl() !== 6'b000100) begin
      n_err++; $display("FAIL load_use_ctl: got %b expected %b", dut_ctl(), 6'b000100);
    end
    tick();
    n_cmp++;
    if (bus.state !== 2'd1 || bus.stallCycles !== 16'd1) begin
      n_err++; $display("FAIL load_use_next: got st=%0d stall=%0d expected st=1 stall=1",
                        bus.state, bus.stallCycles);
    end
    n_cmp++;
    if (dut_ctl() !== 6'b110000) begin
      n_err++; $display("FAIL load_use_masked: got %b expected %b", dut_ctl(), 6'b110000);
    end
    tick();
    set_inputs(1, 0, 0, 0, 1, 0, 0, 0);
    #1;
    n_cmp++;
    if (dut_ctl() !== 6'b110000) begin
      n_err++; $display("FAIL load_x0: got %b expected %b", dut_ctl(), 6'b110000);
    end
    set_inputs(1, 7, 3, 7, 0, 0, 0, 0);
    #1;
    n_cmp++;
    if (dut_ctl() !== 6'b110000) begin
      n_err++; $display("FAIL rt_unused: got %b expected %b", dut_ctl(), 6'b110000);
    end
    set_inputs(1, 7, 3, 7, 1, 0, 0, 0);
    #1;
    n_cmp++;
    if (dut_ctl() !== 6'b000100) begin
      n_err++; $display("FAIL rt_used: got %b expected %b", dut_ctl(), 6'b000100);
    end
    tick();
  endtask

  task automatic test_branch_priority();
    clear_stats();
    set_inputs(1, 5, 5, 0, 0, 1, 0, 0);
    #1;
    n_cmp++;
    if (dut_ctl() !== 6'b111100) begin
      n_err++; $display("FAIL branch_over_load_ctl: got %b expected %b", dut_ctl(), 6'b111100);
    end
    tick();
    n_cmp++;
    if (bus.state !== 2'd2 || bus.flushCount !== 16'd1 || bus.stallCycles !== 16'd0) begin
      n_err++; $display("FAIL branch_next: got st=%0d flush=%0d stall=%0d expected 2/1/0",
                        bus.state, bus.flushCount, bus.stallCycles);
    end
    bus.branchTaken = 1'b0;
    #1;
    n_cmp++;
    if (dut_ctl() !== 6'b110000) begin
      n_err++; $display("FAIL flush_masks_load: got %b expected %b", dut_ctl(), 6'b110000);
    end
    tick();
  endtask

  task automatic test_mem_wait();
    clear_stats();
    set_inputs(1, 5, 5, 0, 0, 1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if (dut_ctl() !== 6'b000011) begin
        n_err++; $display("FAIL mem_wait_ctl[%0d]: got %b expected %b", i, dut_ctl(), 6'b000011);
      end
      tick();
    end
    n_cmp++;
    if (bus.state !== 2'd3) begin
      n_err++; $display("FAIL mem_wait_state: got %0d expected 3", bus.state);
    end
    bus.memoryBusy = 1'b0;
    #1;
    n_cmp++;
    if (dut_ctl() !== 6'b111100) begin
      n_err++; $display("FAIL mem_wait_exit_ctl: got %b expected %b", dut_ctl(), 6'b111100);
    end
    tick();
    n_cmp++;
    if (bus.state !== 2'd2 || bus.stallCycles !== 16'd3 || bus.flushCount !== 16'd1) begin
      n_err++; $display("FAIL mem_wait_exit: got st=%0d stall=%0d flush=%0d expected 2/3/1",
                        bus.state, bus.stallCycles, bus.flushCount);
    end
    set_inputs(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_reset_mid_wait();
    set_inputs(0, 0, 0, 0, 0, 0, 1, 0);
    tick();
    tick();
    #2;
    reset = 1'b1;
    m_state = 2'd0; m_stall = 16'd0; m_flush = 16'd0;
    #1;
    n_cmp++;
    if (bus.state !== 2'd0 || bus.stallCycles !== 16'd0 || bus.flushCount !== 16'd0) begin
      n_err++; $display("FAIL async_reset: got st=%0d stall=%0d flush=%0d expected 0/0/0",
                        bus.state, bus.stallCycles, bus.flushCount);
    end
    tick();
    reset = 1'b0;
    set_inputs(1, 9, 9, 0, 0, 0, 0, 0);
    #1;
    n_cmp++;
    if (dut_ctl() !== 6'b000100) begin
      n_err++; $display("FAIL post_reset_run: got %b expected %b", dut_ctl(), 6'b000100);
    end
    tick();
  endtask

  task automatic test_saturation();
    clear_stats();
    set_inputs(0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 65535; i++) tick();
    n_cmp++;
    if (bus.stallCycles !== 16'hFFFF) begin
      n_err++; $display("FAIL stall_reach_max: got %h expected FFFF", bus.stallCycles);
    end
    tick();
    n_cmp++;
    if (bus.stallCycles !== 16'hFFFF) begin
      n_err++; $display("FAIL stall_saturate: got %h expected FFFF", bus.stallCycles);
    end
    set_inputs(0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    n_cmp++;
    if (bus.stallCycles !== 16'd0) begin
      n_err++; $display("FAIL stat_clear: got %h expected 0000", bus.stallCycles);
    end
    bus.statClear = 1'b0;
  endtask

  task automatic test_random();
    logic [5:0] c;
    logic [1:0] n;
    for (int i = 0; i < 400; i++) begin
      set_inputs(($urandom_range(99) < 60), $urandom_range(3), $urandom_range(3),
                 $urandom_range(3), $urandom_range(1), ($urandom_range(99) < 15),
                 ($urandom_range(99) < 15), ($urandom_range(99) < 4));
      #1;
      model_eval(c, n);
      n_cmp++;
      if (dut_ctl() !== c || bus.state !== m_state) begin
        n_err++; $display("FAIL random_ctl[%0d]: got ctl=%b st=%0d expected ctl=%b st=%0d",
                          i, dut_ctl(), bus.state, c, m_state);
      end
      n_cmp++;
      if (bus.stallCycles !== m_stall || bus.flushCount !== m_flush) begin
        n_err++; $display("FAIL random_cnt[%0d]: got stall=%0d flush=%0d expected %0d/%0d",
                          i, bus.stallCycles, bus.flushCount, m_stall, m_flush);
      end
      tick();
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_load_use();
    test_branch_priority();
    test_mem_wait();
    test_reset_mid_wait();
    test_random();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
